// File: rtl/convertidor_binario_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Takes an N_BITS unsigned value and produces N_DIGITS packed BCD digits over a
// start/busy/done handshake. When the value does not fit, the result saturates
// to all nines and overflow is raised.

// Per-digit correction cell: add 3 to any digit of 5..9 so that doubling it
// carries cleanly into the next digit.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // Digits 0..4 pass through; digits 5..9 are pre-biased by 3
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end
endmodule

module convertidor_binario_bcd_seq #(
  parameter int N_BITS   = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_BITS-1:0]     dato_bin,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int CW    = $clog2(N_BITS + 1);
  localparam int W_BCD = 4 * N_DIGITS;
  localparam int W     = W_BCD + N_BITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      work_q, work_d;   // {BCD working digits, binary remainder}
  logic [CW-1:0]     cnt_q, cnt_d;     // iterations left
  logic              ovf_q, ovf_d;     // sticky: a bit fell off the top digit
  logic [W_BCD-1:0]  bcd_q, bcd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic [N_DIGITS-1:0][3:0] dig_cur, dig_adj;
  logic [W-1:0]             adj, shifted;
  logic                     carry, ovf_next;

  // Add-3 on every working digit in parallel; no carry between digits
  assign dig_cur = work_q[W-1:N_BITS];
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    bcd_add3_digit u_dig (
      .din  (dig_cur[g]),
      .dout (dig_adj[g])
    );
  end

  // Corrected word shifted left; binary MSB moves into digit 0 LSB and the
  // top digit MSB drops out, which only happens once the value outgrows
  // N_DIGITS (the partial value only grows, so the first loss is the real one).
  assign adj      = {dig_adj, work_q[N_BITS-1:0]};
  assign carry    = adj[W-1];
  assign shifted  = {adj[W-2:0], 1'b0};
  assign ovf_next = ovf_q | carry;

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{W_BCD{1'b0}}, dato_bin};
          ovf_d   = 1'b0;
          cnt_d   = CW'(N_BITS);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        ovf_d  = ovf_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d      = ovf_next ? {N_DIGITS{4'h9}} : shifted[W-1:N_BITS];
          overflow_d = ovf_next;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bcd      = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: doc/convertidor_binario_bcd_seq.md
# convertidor_binario_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It takes an `N_BITS`-wide unsigned value and produces `N_DIGITS` packed BCD digits through a start/busy/done handshake. Overflow is flagged and the output saturates when the value does not fit. It sits between the time/date counter registers and the display/VGA text path, replacing fixed-range combinational converters for any field width.

## Interface
- `N_BITS`, 8, width of the binary input; must be ≥ 1.
- `N_DIGITS`, 3, number of BCD output digits; must be ≥ 1.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a conversion; sampled only in IDLE.
- `dato_bin`  input  N_BITS  unsigned binary value, captured on the edge that accepts `start`.
- `bcd`  output  4*N_DIGITS  packed BCD result, digit 0 (units) in bits [3:0]; registered, held until the next completion.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse marking a valid new `bcd`/`overflow`.
- `overflow`  output  1  set when `dato_bin` ≥ 10^N_DIGITS; valid with `done`, held with `bcd`.

## Operation
- FSM has two states, IDLE and SHIFT.
- **Accept (IDLE, `start`=1):**
  - Capture `dato_bin` into the binary shift register.
  - Clear the BCD working register and the sticky overflow flag.
  - Load the bit counter with `N_BITS`, set `busy`=1 and go to SHIFT.
- **Each SHIFT cycle:**
  - Add 3 to every working digit ≥ 5.
  - Shift {BCD working, binary} left by one; the binary MSB enters digit 0 LSB.
  - The bit leaving the top digit MSB ORs into the sticky overflow flag.
  - Decrement the counter.
- **Last iteration (counter = 1):**
  - On this edge, `bcd` loads the final working value.
  - If overflow is set, `bcd` loads all digits = 9 instead.
  - Set `done`=1, clear `busy` and return to IDLE.
- The add-3 step keeps every working digit ≤ 9; no other correction is required.
- **`start` while busy:** ignored, not queued. `dato_bin` changes during a conversion have no effect.
- **Back-to-back:** `start` high in the cycle where `done`=1 (state is already IDLE) is accepted, so there is no idle gap.
- **Width rules:**
  - Counter width is $clog2(N_BITS+1).
  - Working register width is 4*N_DIGITS + N_BITS.
  - Add-3 is performed on 4-bit digits; no carry crosses between digits.

## Timing
- **Reset values:** state IDLE, `bcd`=0, `busy`=0, `done`=0, `overflow`=0, counter=0.
- **Latency:** `start` accepted at edge k, so iterations occur at edges k+1 … k+N_BITS.
  - `busy` is high from after edge k until edge k+N_BITS.
  - `done`, `bcd` and `overflow` update at edge k+N_BITS.
  - Latency from accept to result is N_BITS cycles. Throughput is one conversion per N_BITS+1 cycles when restarting in the `done` cycle.
- `done` is high for exactly one cycle per conversion and never asserts without a preceding accepted `start`.
- `bcd` and `overflow` are stable between `done` pulses.
- **Reset mid-conversion:** aborts immediately. All outputs return to their reset values, no `done` is produced, and the previous `bcd` is lost.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Defaults (8/3), `dato_bin`=59, one `start` pulse -> after 8 cycles `done`=1, `bcd`=0x059, `overflow`=0, `busy` low in the same cycle.
- Defaults, inputs 0, 9, 10 and 255 -> `bcd` = 0x000, 0x009, 0x010, 0x255 respectively. Sweep all 256 inputs against a reference model.
- Back-to-back: convert 9, assert `start` with `dato_bin`=23 in the `done` cycle -> second `done` 8 cycles later with `bcd`=0x023.
  - Extra `start` pulses mid-conversion produce no additional `done`.
- N_BITS=8, N_DIGITS=2:
  - 99 -> `bcd`=0x99, `overflow`=0.
  - 100 -> `bcd`=0x99, `overflow`=1.
  - 200 -> `bcd`=0x99, `overflow`=1.
- N_BITS=16, N_DIGITS=5: 65535 -> `bcd`=0x65535 after 16 cycles; 1000 -> 0x01000.
- Start 59, assert `reset` for one cycle at iteration 4 -> `bcd`=0, `busy`=0, no `done`.
  - A subsequent `start` with 42 -> `bcd`=0x042 after 8 cycles.
